// File: rtl/ahb_acc_master.sv
// AHB-Lite manager for accelerator-initiated word transfers.
// Turns one command into a pipelined single or INCR burst.
module ahb_acc_master #(
    parameter int MAX_LEN = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_LAST,
        S_ERR
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] B_SINGLE  = 3'b000;
    localparam logic [2:0] B_INCR    = 3'b001;
    localparam logic [4:0] LEN_MAX   = 5'(MAX_LEN);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  burst_q, burst_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [4:0]  len_eff;
    logic [1:0]  htrans;
    logic        dphase;
    logic        err_hit;
    logic        wr_pop;

    // Next-state, bus-phase and capture logic for the command FSM.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        burst_d    = burst_q;
        err_d      = err_q;
        done_d     = 1'b0;
        htrans     = TR_IDLE;

        len_eff = cmd_len;
        if (cmd_len == 5'd0) begin
            len_eff = 5'd1;
        end else if (cmd_len > LEN_MAX) begin
            len_eff = LEN_MAX;
        end

        // A data phase is in flight in every state past the first address.
        dphase  = (state_q == S_BURST) || (state_q == S_LAST) ||
                  (state_q == S_ERR);
        err_hit = dphase && (state_q != S_ERR) && HRESP && !HREADY;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_ADDR;
                    write_d = cmd_write;
                    addr_d  = {cmd_addr[31:2], 2'b00};
                    cnt_d   = len_eff - 5'd1;
                    burst_d = (len_eff == 5'd1) ? B_SINGLE : B_INCR;
                    err_d   = 1'b0;
                end
            end
            S_ADDR: begin
                htrans = TR_NONSEQ;
                if (HREADY) begin
                    if (cnt_q == 5'd0) begin
                        state_d = S_LAST;
                    end else begin
                        state_d = S_BURST;
                        addr_d  = addr_q + 32'd4;
                        cnt_d   = cnt_q - 5'd1;
                    end
                end
            end
            S_BURST: begin
                if (err_hit) begin
                    state_d = S_ERR;
                end else begin
                    // Crossing a 1 KB line must restart as NONSEQ.
                    htrans = (addr_q[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                    if (HREADY) begin
                        if (cnt_q == 5'd0) begin
                            state_d = S_LAST;
                        end else begin
                            addr_d = addr_q + 32'd4;
                            cnt_d  = cnt_q - 5'd1;
                        end
                    end
                end
            end
            S_LAST: begin
                if (err_hit) begin
                    state_d = S_ERR;
                end else if (HREADY) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_pop   = write_q && htrans[1] && HREADY;
        hwdata_d = wr_pop ? wr_data : hwdata_q;

        rd_valid_d = !write_q && dphase && (state_q != S_ERR) &&
                     HREADY && !HRESP;
        rd_data_d  = rd_valid_d ? HRDATA : rd_data_q;
    end

    // State and output registers; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            addr_q     <= 32'd0;
            cnt_q      <= 5'd0;
            burst_q    <= B_SINGLE;
            hwdata_q   <= 32'd0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            burst_q    <= burst_d;
            hwdata_q   <= hwdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign wr_ready  = wr_pop;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign HADDR     = addr_q;
    assign HTRANS    = htrans;
    assign HWRITE    = write_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = burst_q;
    assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_acc_master.sv
// Scoreboard bench for ahb_acc_master.
// A reactive AHB subordinate model drives HREADY/HRESP/HRDATA.
module tb_ahb_acc_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [4:0]  cmd_len = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = 32'd0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    ahb_acc_master #(.MAX_LEN(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  t;
        logic        w;
        logic [2:0]  b;
    } ad_t;

    typedef struct {
        logic e;
        int   nw;
        int   nr;
        int   cy;
    } dn_t;

    ad_t         exp_ad[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wd[$];
    dn_t         exp_dn[$];
    logic [31:0] wfifo[$];

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int n_done = 0;
    int target = 0;

    logic [31:0] rdat [16];
    int beat_cnt = 0;
    int wait_beat = -1;
    int wait_n = 0;
    int err_beat = -1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Subordinate model plus show-ahead write FIFO.
    logic dp = 1'b0;
    int   dp_beat = 0;
    int   wl = 0;
    int   es = 0;
    logic pop_pend = 1'b0;

    always @(negedge clk) begin
        if (pop_pend && wfifo.size() > 0) void'(wfifo.pop_front());
        pop_pend = 1'b0;
        if (!reset_n || !dp) begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
        end else if (dp_beat == err_beat && es == 0) begin
            HREADY = 1'b0;
            HRESP  = 1'b1;
            es     = 1;
        end else if (es == 1) begin
            HREADY = 1'b1;
            HRESP  = 1'b1;
            es     = 2;
        end else if (wl > 0) begin
            HREADY = 1'b0;
            HRESP  = 1'b0;
            wl--;
        end else begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
            HRDATA = rdat[dp_beat];
        end
        wr_data = (wfifo.size() > 0) ? wfifo[0] : 32'd0;
        #1;
        wr_data = (wfifo.size() > 0) ? wfifo[0] : 32'd0;
        if (!reset_n) begin
            dp = 1'b0;
        end else begin
            pop_pend = wr_ready;
            if (HREADY) dp = 1'b0;
            if (HREADY && HTRANS[1]) begin
                dp      = 1'b1;
                dp_beat = beat_cnt;
                wl      = (beat_cnt == wait_beat) ? wait_n : 0;
                es      = 0;
                beat_cnt++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT shows an event.
    logic wdp = 1'b0;
    int   nwr = 0;
    int   nrd = 0;

    always @(negedge clk) begin
        ad_t         ea;
        dn_t         ed;
        logic [31:0] ev;
        #2;
        if (!reset_n) begin
            wdp = 1'b0;
            nwr = 0;
            nrd = 0;
        end else begin
            if (HRESP && !HREADY) chk("htrans_on_error", 32'(HTRANS), 32'd0);
            if (wdp && HREADY) begin
                if (!HRESP) begin
                    if (exp_wd.size() == 0) chk("hwdata_unexpected", 32'd1, 32'd0);
                    else begin
                        ev = exp_wd.pop_front();
                        chk("hwdata", HWDATA, ev);
                    end
                end
                wdp = 1'b0;
            end
            if (HTRANS[1] && HREADY) begin
                if (exp_ad.size() == 0) chk("addr_unexpected", HADDR, 32'hFFFF_FFFF);
                else begin
                    ea = exp_ad.pop_front();
                    chk("haddr", HADDR, ea.a);
                    chk("htrans", 32'(HTRANS), 32'(ea.t));
                    chk("hwrite", 32'(HWRITE), 32'(ea.w));
                    chk("hburst", 32'(HBURST), 32'(ea.b));
                    chk("hsize", 32'(HSIZE), 32'd2);
                end
                wdp = HWRITE;
            end
            if (wr_ready) nwr++;
            if (rd_valid) begin
                nrd++;
                if (exp_rd.size() == 0) chk("rd_unexpected", rd_data, 32'hFFFF_FFFF);
                else begin
                    ev = exp_rd.pop_front();
                    chk("rd_data", rd_data, ev);
                end
            end
            if (done) begin
                if (exp_dn.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else begin
                    ed = exp_dn.pop_front();
                    chk("done_err", 32'(err), 32'(ed.e));
                    chk("done_nwr", 32'(nwr), 32'(ed.nw));
                    chk("done_nrd", 32'(nrd), 32'(ed.nr));
                    chk("done_cycle", 32'(cyc), 32'(ed.cy));
                    chk("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
                end
                nwr = 0;
                nrd = 0;
                n_done++;
            end
        end
    end

    task automatic pa(input logic [31:0] a, input logic [1:0] t,
                      input logic w, input logic [2:0] b);
        ad_t x;
        x.a = a; x.t = t; x.w = w; x.b = b;
        exp_ad.push_back(x);
    endtask

    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [4:0] len, input int lat,
                         input logic e, input int nw, input int nr);
        dn_t d;
        int  n;
        int  hs;
        @(negedge clk);
        beat_cnt  = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = len;
        #1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("cmd_ready_timeout", 32'd0, 32'd1);
        hs = cyc;
        d.e = e; d.nw = nw; d.nr = nr; d.cy = hs + lat;
        exp_dn.push_back(d);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        target++;
        n = 0;
        while (n_done < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(n_done >= target), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_htrans"}, 32'(HTRANS), 32'd0);
        chk({tag, "_haddr"}, HADDR, 32'd0);
        chk({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
        chk({tag, "_hburst"}, 32'(HBURST), 32'd0);
        chk({tag, "_hwdata"}, HWDATA, 32'd0);
        chk({tag, "_hsize"}, 32'(HSIZE), 32'd2);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rdat[i] = 32'd0;
        #13;
        chk_reset_vals("por");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Single zero-wait write.
        wfifo.push_back(32'hDEAD_BEEF);
        pa(32'h100, 2'b10, 1'b1, 3'b000);
        exp_wd.push_back(32'hDEAD_BEEF);
        issue(1'b1, 32'h100, 5'd1, 3, 1'b0, 1, 0);
        wait_done();

        // 4-beat read with two wait states on beat 2.
        rdat[0] = 32'h11; rdat[1] = 32'h22;
        rdat[2] = 32'h33; rdat[3] = 32'h44;
        wait_beat = 1; wait_n = 2;
        pa(32'h2000, 2'b10, 1'b0, 3'b001);
        pa(32'h2004, 2'b11, 1'b0, 3'b001);
        pa(32'h2008, 2'b11, 1'b0, 3'b001);
        pa(32'h200C, 2'b11, 1'b0, 3'b001);
        exp_rd.push_back(32'h11); exp_rd.push_back(32'h22);
        exp_rd.push_back(32'h33); exp_rd.push_back(32'h44);
        issue(1'b0, 32'h2001, 5'd4, 8, 1'b0, 0, 4);
        wait_done();
        wait_beat = -1; wait_n = 0;

        // 4-beat write crossing the 1 KB line.
        for (int i = 0; i < 4; i++) begin
            wfifo.push_back(32'hA0 + 32'(i));
            exp_wd.push_back(32'hA0 + 32'(i));
        end
        pa(32'h3F8, 2'b10, 1'b1, 3'b001);
        pa(32'h3FC, 2'b11, 1'b1, 3'b001);
        pa(32'h400, 2'b10, 1'b1, 3'b001);
        pa(32'h404, 2'b11, 1'b1, 3'b001);
        issue(1'b1, 32'h3F8, 5'd4, 6, 1'b0, 4, 0);
        wait_done();

        // 3-beat read, ERROR on beat 2.
        rdat[0] = 32'hA1; rdat[1] = 32'hA2; rdat[2] = 32'hA3;
        err_beat = 1;
        pa(32'h600, 2'b10, 1'b0, 3'b001);
        pa(32'h604, 2'b11, 1'b0, 3'b001);
        exp_rd.push_back(32'hA1);
        issue(1'b0, 32'h600, 5'd3, 5, 1'b1, 0, 1);
        wait_done();
        err_beat = -1;
        @(negedge clk);
        #1;
        chk("err_held", 32'(err), 32'd1);

        // Next command clears err on acceptance.
        wfifo.push_back(32'h5555_AAAA);
        exp_wd.push_back(32'h5555_AAAA);
        pa(32'h40, 2'b10, 1'b1, 3'b000);
        issue(1'b1, 32'h40, 5'd1, 3, 1'b0, 1, 0);
        chk("err_cleared", 32'(err), 32'd0);
        wait_done();

        // cmd_len = 0 runs as a single beat.
        rdat[0] = 32'hCAFE_0000;
        pa(32'h500, 2'b10, 1'b0, 3'b000);
        exp_rd.push_back(32'hCAFE_0000);
        issue(1'b0, 32'h500, 5'd0, 3, 1'b0, 0, 1);
        wait_done();

        // cmd_len = 31 clamps to 16 beats; address wraps past 0.
        for (int i = 0; i < 16; i++) begin
            rdat[i] = 32'h1000 + 32'(i);
            exp_rd.push_back(32'h1000 + 32'(i));
            pa(32'hFFFF_FFF8 + 32'(i * 4),
               (i == 0 || i == 2) ? 2'b10 : 2'b11, 1'b0, 3'b001);
        end
        issue(1'b0, 32'hFFFF_FFF8, 5'd31, 18, 1'b0, 0, 16);
        wait_done();

        // Reset in the middle of a burst.
        for (int i = 0; i < 16; i++) begin
            exp_rd.push_back(32'h1000 + 32'(i));
            pa(32'h8000 + 32'(i * 4), (i == 0) ? 2'b10 : 2'b11,
               1'b0, 3'b001);
        end
        issue(1'b0, 32'h8000, 5'd16, 18, 1'b0, 0, 16);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        exp_ad.delete();
        exp_rd.delete();
        exp_wd.delete();
        exp_dn.delete();
        wfifo.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        rdat[0] = 32'h77;
        pa(32'h10, 2'b10, 1'b0, 3'b000);
        exp_rd.push_back(32'h77);
        issue(1'b0, 32'h10, 5'd1, 3, 1'b0, 0, 1);
        wait_done();

        repeat (3) @(negedge clk);
        chk("leftover_expect",
            32'(exp_ad.size() + exp_rd.size() + exp_wd.size() +
                exp_dn.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
